rtp_result_collector: RTL

Receiving end of the RTP result path. Accepts per-ray hit results (ray id, hitT, triangle id) from the traversal/intersection pipeline through a valid/ready stream and buffers them in a small FIFO. Writes each result into a result RAM indexed by ray id, counts unique rays and misses, and asserts completion once every ray of the batch has reported. The bench or host reads the RAM back through a registered read port; this replaces end-of-run dumping of `io_hitT`/`io_ray_id_triangle`.

---
 rtl/rtp_result_pkg.sv | 23 ++
 rtl/rtp_result_fifo.sv | 51 +++++
 rtl/rtp_result_collector.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rtp_result_pkg.sv
// Shared types and constants for the RTP result collector.
package rtp_result_pkg;

  localparam logic [31:0] MISS_TRI_ID = 32'hFFFF_FFFF;
  localparam logic [31:0] HIT_T_INF   = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] ray_id;
    logic [31:0] hitT;
    logic [31:0] tri_id;
  } rtp_result_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } rtp_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rtp_result_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two >= 2.
module rtp_result_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rtp_result_collector.sv
// Collects per-ray hit results into a ray-indexed result RAM with unique/miss
// counting, duplicate/out-of-range flags and a registered readback port.
module rtp_result_collector
  import rtp_result_pkg::*;
#(
  parameter int NUM_RAYS   = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(NUM_RAYS)
) (
  input  logic          clock,
  input  logic          reset,
  // io_in stream: a beat transfers on a rising edge where io_in_valid && io_in_ready;
  // ready depends only on registered state, never on valid or on the current pop.
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic [31:0]   io_in_ray_id,
  input  logic [31:0]   io_in_hitT,
  input  logic [31:0]   io_in_tri_id,
  input  logic          io_rd_en,
  input  logic [AW-1:0] io_rd_addr,
  output logic          io_rd_valid,
  output logic [31:0]   io_rd_hitT,
  output logic [31:0]   io_rd_tri_id,
  output logic          io_busy_clear,
  output logic          io_done,
  output logic [31:0]   io_ray_count,
  output logic [31:0]   io_miss_count,
  output logic          io_err_oob,
  output logic          io_err_dup,
  output logic [1:0]    io_dbg_state
);

  rtp_state_e       state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic [31:0]      ray_count_q, ray_count_d;
  logic [31:0]      miss_count_q, miss_count_d;
  logic             err_oob_q, err_oob_d;
  logic             err_dup_q, err_dup_d;
  logic [NUM_RAYS-1:0] written_q;
  logic [63:0]      ram_q [NUM_RAYS];
  logic             rd_valid_q;
  logic [63:0]      rd_data_q;

  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [95:0]      fifo_rdata;
  rtp_result_t      head;
  logic             head_oob, proc_new, proc_dup;
  logic [AW-1:0]    head_addr;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [63:0]      ram_wdata;

  assign io_in_ready = (state_q == ST_RUN) && !fifo_full;
  assign fifo_push   = io_in_valid && io_in_ready;
  assign fifo_pop    = !fifo_empty && (state_q != ST_CLEAR);

  rtp_result_fifo #(
    .WIDTH (96),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i ({io_in_ray_id, io_in_hitT, io_in_tri_id}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head      = rtp_result_t'(fifo_rdata);
  assign head_oob  = (head.ray_id >= 32'(NUM_RAYS));
  assign head_addr = head.ray_id[AW-1:0];
  assign proc_new  = fifo_pop && !head_oob && !written_q[head_addr];
  assign proc_dup  = fifo_pop && !head_oob &&  written_q[head_addr];

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    ray_count_d  = ray_count_q;
    miss_count_d = miss_count_q;
    err_oob_d    = err_oob_q | (fifo_pop && head_oob);
    err_dup_d    = err_dup_q | proc_dup;
    ram_we       = fifo_pop && !head_oob;
    ram_waddr    = head_addr;
    ram_wdata    = {head.hitT, head.tri_id};
    if (proc_new) begin
      ray_count_d = sat_inc(ray_count_q);
      if (head.tri_id == MISS_TRI_ID) miss_count_d = sat_inc(miss_count_q);
    end
    case (state_q)
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = {HIT_T_INF, MISS_TRI_ID};
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(NUM_RAYS - 1)) begin
          state_d    = ST_RUN;
          clr_addr_d = '0;
        end
      end
      ST_RUN: begin
        if (ray_count_d == 32'(NUM_RAYS)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      ray_count_q  <= '0;
      miss_count_q <= '0;
      err_oob_q    <= 1'b0;
      err_dup_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      ray_count_q  <= ray_count_d;
      miss_count_q <= miss_count_d;
      err_oob_q    <= err_oob_d;
      err_dup_q    <= err_dup_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      written_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      written_q[clr_addr_q] <= 1'b0;
    end else if (proc_new) begin
      written_q[head_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  // Read samples the array before this edge's write lands, so same-address collisions return old data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= io_rd_en && (state_q != ST_CLEAR);
      if (io_rd_en && (state_q != ST_CLEAR)) rd_data_q <= ram_q[io_rd_addr];
    end
  end

  assign io_rd_valid   = rd_valid_q;
  assign io_rd_hitT    = rd_data_q[63:32];
  assign io_rd_tri_id  = rd_data_q[31:0];
  assign io_busy_clear = (state_q == ST_CLEAR);
  assign io_done       = (state_q == ST_DONE);
  assign io_ray_count  = ray_count_q;
  assign io_miss_count = miss_count_q;
  assign io_err_oob    = err_oob_q;
  assign io_err_dup    = err_dup_q;
  assign io_dbg_state  = state_q;

endmodule
